// File: rtl/mem_port_ctrl_pkg.sv
// Shared encodings, state type and alignment rule for the memory port controller.
// No timing of its own; pure declarations and a combinational helper.
// No flow control here; consumers apply the rule at request accept.
package mem_port_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } mp_state_t;

   // A request is rejected when its size is illegal or the address is not
   // naturally aligned for that size.
   function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] addr_lo);
      logic err;
      err = 1'b1;
      case (size)
         SZ_BYTE: err = 1'b0;
         SZ_HALF: err = addr_lo[0];
         SZ_WORD: err = |addr_lo;
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Request/response channel between the control path and the memory port.
// No latency; bundle of wires only.
// req_valid is held by the initiator until req_ready is seen high.
interface mem_port_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/mem_lane_align.sv
// Lane extract/extend for loads and lane merge for sub-word stores (little-endian).
// Purely combinational, zero latency.
// No flow control; follows whatever word/addr the caller presents.
module mem_lane_align
   import mem_port_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic [31:0] st_word
);

   logic [31:0] shifted;

   // Load side: bring the addressed lane down to bit 0 and extend it.
   always_comb begin
      shifted = word_i >> {addr_lo, 3'b000};
      ld_data = word_i;
      case (size)
         SZ_BYTE: ld_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
         SZ_HALF: ld_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
         default: ld_data = word_i;
      endcase
   end

   // Store side: overwrite only the addressed lane(s) of the old word.
   always_comb begin
      st_word = word_i;
      case (size)
         SZ_BYTE: st_word[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
         SZ_HALF: st_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
         default: st_word = wdata;
      endcase
   end

endmodule

// File: rtl/mem_port_ctrl.sv
// Single-outstanding load/store responder with sub-word read-modify-write.
// Load MEM_LAT+2, word store 2, sub-word store MEM_LAT+3, error 1 cycle after accept.
// req_ready only in IDLE; one request in flight, none accepted during RESP.
module mem_port_ctrl
   import mem_port_pkg::*;
#(
   parameter int MEM_LAT = 1
)(
   input  logic            clk,
   input  logic            reset,
   mem_port_ctrl_if.slave  req_if,
   output logic [31:0]     mem_addr,
   output logic            mem_wr,
   output logic [31:0]     mem_wdata,
   input  logic [31:0]     mem_rdata
);

   localparam logic [2:0] CNT_LAST = 3'(MEM_LAT);

   mp_state_t   state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] word_q, word_d;

   logic [31:0] ld_data;
   logic [31:0] st_word;

   mem_lane_align u_align (
      .word_i      (word_q),
      .addr_lo     (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (uns_q),
      .wdata       (wdata_q),
      .ld_data     (ld_data),
      .st_word     (st_word)
   );

   // Next-state: accept/classify in IDLE, count read latency in RD.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      size_d  = size_q;
      uns_d   = uns_q;
      we_d    = we_q;
      err_d   = err_q;
      wdata_d = wdata_q;
      word_d  = word_q;
      case (state_q)
         ST_IDLE: begin
            if (req_if.req_valid) begin
               addr_d  = req_if.req_addr;
               size_d  = req_if.req_size;
               uns_d   = req_if.req_unsigned;
               we_d    = req_if.req_we;
               wdata_d = req_if.req_wdata;
               err_d   = req_is_err(req_if.req_size, req_if.req_addr[1:0]);
               cnt_d   = '0;
               if (err_d)
                  state_d = ST_RESP;
               else if (req_if.req_we && req_if.req_size == SZ_WORD)
                  state_d = ST_WR;
               else
                  state_d = ST_RD;
            end
         end
         ST_RD: begin
            if (cnt_q == CNT_LAST) begin
               word_d  = mem_rdata;
               cnt_d   = '0;
               state_d = we_q ? ST_WR : ST_RESP;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         ST_WR:   state_d = ST_RESP;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and request registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         we_q    <= we_d;
         err_q   <= err_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
      end
   end

   // Outputs decoded from registered state only; ready is also gated by reset.
   always_comb begin
      req_if.req_ready  = (state_q == ST_IDLE) & ~reset;
      req_if.resp_valid = (state_q == ST_RESP);
      req_if.resp_err   = (state_q == ST_RESP) & err_q;
      req_if.resp_rdata = ((state_q == ST_RESP) && !we_q && !err_q) ? ld_data : 32'h0;
      mem_addr          = (state_q == ST_RD || state_q == ST_WR) ? {addr_q[31:2], 2'b00} : 32'h0;
      mem_wr            = (state_q == ST_WR);
      mem_wdata         = (state_q == ST_WR) ? st_word : 32'h0;
   end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a one-cycle-latency word memory model.
// Cycle numbers below are counted from the accept edge (n=1 is the cycle after accept).
// Outputs are sampled on the falling edge, inputs driven there too.
module tb_mem_port_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_wr;

   mem_port_ctrl_if bus ();

   mem_port_ctrl #(.MEM_LAT(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_if    (bus),
      .mem_addr  (mem_addr),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: 256 words, registered read data (latency 1).
   logic [31:0] mem [0:255];
   logic [31:0] rd_q;
   logic        mem_init_done = 1'b0;
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[64] <= 32'h8899AABB;
         mem_init_done <= 1'b1;
      end else if (mem_wr) begin
         mem[mem_addr[9:2]] <= mem_wdata;
      end
      rd_q <= mem[mem_addr[9:2]];
   end
   assign mem_rdata = rd_q;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Results of the last run_op call.
   int          o_lat, o_wr_n, o_wr_cnt;
   logic [31:0] o_wr_dat, o_wr_adr, o_rdata;
   logic        o_err, o_rdy_low;

   // Issue one request from IDLE, follow it to its response, return to IDLE.
   task automatic run_op(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
      logic done;
      chk({tag, "_ready"}, {31'h0, bus.req_ready}, 32'h1);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      o_lat = -1; o_wr_n = -1; o_wr_cnt = 0;
      o_wr_dat = 32'h0; o_wr_adr = 32'h0; o_rdata = 32'hx; o_err = 1'bx;
      o_rdy_low = 1'b1;
      done = 1'b0;
      for (int n = 1; n <= 20 && !done; n++) begin
         if (n > 1) @(negedge clk);
         if (mem_wr) begin
            o_wr_cnt++;
            o_wr_n   = n;
            o_wr_dat = mem_wdata;
            o_wr_adr = mem_addr;
         end
         if (bus.req_ready) o_rdy_low = 1'b0;
         if (bus.resp_valid) begin
            o_lat   = n;
            o_rdata = bus.resp_rdata;
            o_err   = bus.resp_err;
            done    = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   // Back-to-back trace storage.
   logic        b_rv  [1:12];
   logic        b_rdy [1:12];
   logic        b_wr  [1:12];
   logic [31:0] b_rd  [1:12];
   logic [31:0] b_wd  [1:12];
   int          acc_n;
   int          wr_seen;
   int          rv_seen;

   initial begin
      reset = 1'b1;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

      // Reset state: everything quiet, including req_ready.
      repeat (3) @(negedge clk);
      chk("rst_ready",  {31'h0, bus.req_ready},  32'h0);
      chk("rst_rvalid", {31'h0, bus.resp_valid}, 32'h0);
      chk("rst_mem_wr", {31'h0, mem_wr},         32'h0);
      chk("rst_addr",   mem_addr,                32'h0);
      chk("rst_wdata",  mem_wdata,               32'h0);
      reset = 1'b0;
      #1;
      chk("rst_rel_ready", {31'h0, bus.req_ready}, 32'h1);
      @(negedge clk);

      // Signed byte load from lane 1.
      run_op("lb", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0);
      chk("lb_data", o_rdata, 32'hFFFFFFAA);
      chk("lb_lat",  32'(o_lat), 32'd3);
      chk("lb_wr",   32'(o_wr_cnt), 32'd0);
      chk("lb_err",  {31'h0, o_err}, 32'h0);
      chk("lb_busy", {31'h0, o_rdy_low}, 32'h1);

      // Unsigned and signed half loads from the upper pair.
      run_op("lhu", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
      chk("lhu_data", o_rdata, 32'h00008899);
      chk("lhu_err",  {31'h0, o_err}, 32'h0);
      run_op("lh", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
      chk("lh_data", o_rdata, 32'hFFFF8899);

      // Unsigned byte load from lane 0.
      run_op("lbu", 1'b0, 2'b00, 1'b1, 32'h100, 32'h0);
      chk("lbu_data", o_rdata, 32'h000000BB);

      // Byte store into lane 3: read-modify-write.
      run_op("sb", 1'b1, 2'b00, 1'b0, 32'h103, 32'h12345677);
      chk("sb_wr_cnt", 32'(o_wr_cnt), 32'd1);
      chk("sb_wr_n",   32'(o_wr_n),   32'd3);
      chk("sb_wdata",  o_wr_dat,      32'h7799AABB);
      chk("sb_waddr",  o_wr_adr,      32'h100);
      chk("sb_lat",    32'(o_lat),    32'd4);
      chk("sb_rdata",  o_rdata,       32'h0);
      chk("sb_mem",    mem[64],       32'h7799AABB);

      // Word load reads back the merged word.
      run_op("lw", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
      chk("lw_data", o_rdata, 32'h7799AABB);

      // Misaligned word store: immediate error, no write.
      run_op("sw_mis", 1'b1, 2'b10, 1'b0, 32'h102, 32'hFFFFFFFF);
      chk("swm_lat",   32'(o_lat), 32'd1);
      chk("swm_err",   {31'h0, o_err}, 32'h1);
      chk("swm_wr",    32'(o_wr_cnt), 32'd0);
      chk("swm_rdata", o_rdata, 32'h0);
      chk("swm_mem",   mem[64], 32'h7799AABB);

      // Illegal size.
      run_op("sz3", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
      chk("sz3_lat", 32'(o_lat), 32'd1);
      chk("sz3_err", {31'h0, o_err}, 32'h1);

      // Half store into upper pair of word 0x104 (initially 0).
      run_op("sh", 1'b1, 2'b01, 1'b0, 32'h106, 32'hCAFE1234);
      chk("sh_wdata", o_wr_dat, 32'h12340000);
      chk("sh_lat",   32'(o_lat), 32'd4);
      chk("sh_mem",   mem[65], 32'h12340000);

      // Reset during RD of a half store: aborted, no write, no response.
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b01;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h100; bus.req_wdata = 32'h00005555;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("ab_rd_addr", mem_addr, 32'h100);
      reset = 1'b1;
      #1;
      chk("ab_mem_wr", {31'h0, mem_wr}, 32'h0);
      chk("ab_ready",  {31'h0, bus.req_ready}, 32'h0);
      wr_seen = 0; rv_seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (mem_wr) wr_seen++;
         if (bus.resp_valid) rv_seen++;
      end
      reset = 1'b0;
      #1;
      chk("ab_ready_rel", {31'h0, bus.req_ready}, 32'h1);
      repeat (4) begin
         @(negedge clk);
         if (mem_wr) wr_seen++;
         if (bus.resp_valid) rv_seen++;
      end
      chk("ab_no_wr",   32'(wr_seen), 32'd0);
      chk("ab_no_resp", 32'(rv_seen), 32'd0);
      chk("ab_mem",     mem[64], 32'h7799AABB);

      // Back-to-back: load 0x100 then word store 0x104, req_valid held high.
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h100; bus.req_wdata = 32'h0;
      @(posedge clk);
      #1;
      bus.req_we = 1'b1; bus.req_addr = 32'h104; bus.req_wdata = 32'hDEADBEEF;
      acc_n = -1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         b_rv[n]  = bus.resp_valid;
         b_rdy[n] = bus.req_ready;
         b_wr[n]  = mem_wr;
         b_rd[n]  = bus.resp_rdata;
         b_wd[n]  = mem_wdata;
         if (bus.req_ready && bus.req_valid) begin
            acc_n = n;
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
         end
      end
      chk("b2b_busy1", {29'h0, b_rdy[1], b_rdy[2], b_rdy[3]}, 32'h0);
      chk("b2b_rv1",   {29'h0, b_rv[1], b_rv[2], b_rv[3]}, 32'h1);
      chk("b2b_ld",    b_rd[3], 32'h7799AABB);
      chk("b2b_acc2",  32'(acc_n), 32'd4);
      chk("b2b_wr5",   {31'h0, b_wr[5]}, 32'h1);
      chk("b2b_wd5",   b_wd[5], 32'hDEADBEEF);
      chk("b2b_busy2", {30'h0, b_rdy[5], b_rdy[6]}, 32'h0);
      chk("b2b_rv6",   {31'h0, b_rv[6]}, 32'h1);
      chk("b2b_st_rd", b_rd[6], 32'h0);
      chk("b2b_rdy7",  {31'h0, b_rdy[7]}, 32'h1);
      chk("b2b_wr_other", {28'h0, b_wr[3], b_wr[4], b_wr[6], b_wr[7]}, 32'h0);
      chk("b2b_mem",   mem[65], 32'hDEADBEEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
